// File: rtl/apb_to_ahbl.sv
// APB3 completer to AHB-Lite manager bridge: each APB access becomes one 32-bit
// SINGLE AHB transfer, with the APB side held off until the AHB data phase ends.
`timescale 1ns/1ps
module apb_to_ahbl #(
  parameter int          W_PADDR    = 16,
  parameter int          W_HADDR    = 32,
  parameter int          W_DATA     = 32,
  parameter logic [31:0] HADDR_BASE = 32'h0000_0000,
  parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               apbs_psel,
  input  logic               apbs_penable,
  input  logic               apbs_pwrite,
  input  logic [W_PADDR-1:0] apbs_paddr,
  input  logic [W_DATA-1:0]  apbs_pwdata,
  output logic [W_DATA-1:0]  apbs_prdata,
  output logic               apbs_pready,
  output logic               apbs_pslverr,
  output logic [W_HADDR-1:0] ahblm_haddr,
  output logic               ahblm_hwrite,
  output logic [1:0]         ahblm_htrans,
  output logic [2:0]         ahblm_hsize,
  output logic [2:0]         ahblm_hburst,
  output logic [3:0]         ahblm_hprot,
  output logic               ahblm_hmastlock,
  input  logic               ahblm_hready,
  input  logic               ahblm_hresp,
  output logic [W_DATA-1:0]  ahblm_hwdata,
  input  logic [W_DATA-1:0]  ahblm_hrdata
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;
  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  state_t             state_q, state_d;
  logic [1:0]         htrans_q, htrans_d;
  logic [W_HADDR-1:0] haddr_q, haddr_d;
  logic               hwrite_q, hwrite_d;
  logic [W_DATA-1:0]  hwdata_q, hwdata_d;
  logic [W_DATA-1:0]  prdata_q, prdata_d;
  logic               pready_q, pready_d;
  logic               pslverr_q, pslverr_d;
  logic [W_HADDR-1:0] word_addr;

  assign word_addr = W_HADDR'({apbs_paddr[W_PADDR-1:2], 2'b00});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      htrans_q  <= HT_IDLE;
      haddr_q   <= '0;
      hwrite_q  <= 1'b0;
      hwdata_q  <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      htrans_q  <= htrans_d;
      haddr_q   <= haddr_d;
      hwrite_q  <= hwrite_d;
      hwdata_q  <= hwdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    htrans_d  = HT_IDLE;
    haddr_d   = haddr_q;
    hwrite_d  = hwrite_q;
    hwdata_d  = hwdata_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (apbs_psel && !apbs_penable) begin
          haddr_d  = HADDR_BASE[W_HADDR-1:0] | word_addr;
          hwrite_d = apbs_pwrite;
          hwdata_d = apbs_pwdata;
          // Misaligned accesses are refused locally; the AHB side never sees them.
          if (apbs_paddr[1:0] != 2'b00) begin
            state_d   = S_RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else begin
            state_d  = S_ADDR;
            htrans_d = HT_NONSEQ;
          end
        end
      end
      S_ADDR: begin
        if (ahblm_hready) state_d = S_DATA;
        else              htrans_d = HT_NONSEQ;
      end
      S_DATA: begin
        if (ahblm_hready) begin
          state_d   = S_RESP;
          pready_d  = 1'b1;
          pslverr_d = ahblm_hresp;
          if (!ahblm_hresp && !hwrite_q) prdata_d = ahblm_hrdata;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign apbs_prdata     = prdata_q;
  assign apbs_pready     = pready_q;
  assign apbs_pslverr    = pslverr_q;
  assign ahblm_haddr     = haddr_q;
  assign ahblm_hwrite    = hwrite_q;
  assign ahblm_htrans    = htrans_q;
  assign ahblm_hwdata    = hwdata_q;
  assign ahblm_hsize     = 3'b010;
  assign ahblm_hburst    = 3'b000;
  assign ahblm_hprot     = HPROT_VAL;
  assign ahblm_hmastlock = 1'b0;

endmodule

// File: tb/tb_apb_to_ahbl.sv
// Directed bench for apb_to_ahbl: a timeline model predicts each cycle's outputs
// from the transaction descriptor and the scripted slave wait/error pattern.
`timescale 1ns/1ps
module tb_apb_to_ahbl;
  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        clk, rst;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [31:0] haddr, hwdata, hrdata;
  logic        hwrite, hmastlock, hready, hresp;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;

  apb_to_ahbl #(.HADDR_BASE(BASE)) u_dut (
    .clk(clk), .rst(rst),
    .apbs_psel(psel), .apbs_penable(penable), .apbs_pwrite(pwrite),
    .apbs_paddr(paddr), .apbs_pwdata(pwdata), .apbs_prdata(prdata),
    .apbs_pready(pready), .apbs_pslverr(pslverr),
    .ahblm_haddr(haddr), .ahblm_hwrite(hwrite), .ahblm_htrans(htrans),
    .ahblm_hsize(hsize), .ahblm_hburst(hburst), .ahblm_hprot(hprot),
    .ahblm_hmastlock(hmastlock), .ahblm_hready(hready), .ahblm_hresp(hresp),
    .ahblm_hwdata(hwdata), .ahblm_hrdata(hrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Current transaction descriptor; k is the cycle offset from its setup cycle.
  logic        t_aligned = 1'b0, t_write = 1'b0, t_err = 1'b0;
  logic [15:0] t_addr = '0;
  logic [31:0] t_wdata = '0, t_rdata = '0;
  int          t_aw = 0, t_dw = 0, end_k = -1, k = 1000;
  logic [31:0] mdl_prdata = '0;
  int          obs_lat, n_nonseq, n_pready;
  logic [31:0] obs_haddr;

  initial begin
    bit nonseq, datap, rdy;
    forever begin
      @(negedge clk);
      if (rst) begin
        mdl_prdata = '0;
      end else begin
        nonseq = t_aligned && k >= 1 && k <= 1 + t_aw;
        datap  = t_aligned && k >= 2 + t_aw && k <= 2 + t_aw + t_dw;
        rdy    = (k == end_k);
        if (rdy && t_aligned && !t_write && !t_err) mdl_prdata = t_rdata;
        check("htrans",  {30'd0, htrans}, nonseq ? 32'd2 : 32'd0);
        check("pready",  {31'd0, pready}, {31'd0, rdy});
        check("pslverr", {31'd0, pslverr}, {31'd0, rdy && (!t_aligned || t_err)});
        check("prdata",  prdata, mdl_prdata);
        check("consts",  {20'd0, hsize, hburst, hprot, hmastlock, 1'b0}, {20'd0, 3'b010, 3'b000, 4'b0011, 2'b00});
        if (nonseq) begin
          check("haddr",  haddr, BASE | {16'd0, t_addr & 16'hfffc});
          check("hwrite", {31'd0, hwrite}, {31'd0, t_write});
        end
        if (datap && t_write) check("hwdata", hwdata, t_wdata);
        if (k == 0) begin obs_lat = -1; n_nonseq = 0; n_pready = 0; end
        if (pready) begin n_pready++; if (obs_lat < 0) obs_lat = k; end
        if (htrans == 2'b10) begin n_nonseq++; obs_haddr = haddr; end
      end
    end
  end

  task automatic drive_idle_slave();
    hready = 1'b0; hresp = 1'b1; hrdata = 32'hdeadbeef;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      k++;
      psel = 1'b0; penable = 1'b0;
      drive_idle_slave();
    end
  endtask

  // One APB access; aw/dw are AHB wait states in address/data phase, err makes
  // the last dw cycle plus the completing cycle an ERROR response.
  task automatic run(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                     input int aw, input int dw, input logic err,
                     input logic [31:0] rd, input int rst_at);
    int ek;
    ek = (a[1:0] != 2'b00) ? 1 : 3 + aw + dw;
    for (int i = 0; i <= ek + 1; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        t_aligned = (a[1:0] == 2'b00); t_write = wr; t_err = err;
        t_addr = a; t_wdata = wd; t_rdata = rd; t_aw = aw; t_dw = dw; end_k = ek;
      end
      k = i;
      psel = (i <= ek); penable = (i >= 1 && i <= ek);
      pwrite = wr; paddr = a; pwdata = wd;
      hready = 1'b1; hresp = 1'b0; hrdata = 32'hdeadbeef;
      if (i == 0 || i >= ek || !t_aligned) drive_idle_slave();
      else begin
        if (i <= aw) hready = 1'b0;
        if (i >= 2 + aw && i <= 1 + aw + dw) hready = 1'b0;
        if (err && dw >= 1 && (i == 1 + aw + dw || i == 2 + aw + dw)) hresp = 1'b1;
        if (i == 2 + aw + dw) hrdata = rd;
      end
      if (i == rst_at) begin
        #2 rst = 1'b1;
        #1;
        check("rst_htrans", {30'd0, htrans}, 32'd0);
        check("rst_pready", {30'd0, pready, pslverr}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_haddr",  haddr, 32'd0);
        check("rst_hwrite", {31'd0, hwrite}, 32'd0);
        check("rst_hwdata", hwdata, 32'd0);
        k = 1000; end_k = -1; t_aligned = 1'b0;
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; drive_idle_slave();
    #2;
    check("reset_out", {htrans, pready, pslverr, hwrite}, 32'd0);
    check("reset_data", prdata | haddr | hwdata, 32'd0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    idle(2);

    run(1'b1, 16'h0010, 32'hcafef00d, 0, 0, 1'b0, 32'h0, -1);
    check("c1_lat", obs_lat, 32'd3);
    check("c1_haddr", obs_haddr, 32'h2000_0010);
    check("c1_nonseq", n_nonseq, 32'd1);
    idle(1);

    run(1'b0, 16'h0004, 32'h0, 0, 3, 1'b0, 32'h1234_5678, -1);
    check("c2_lat", obs_lat, 32'd6);
    check("c2_prdata", prdata, 32'h1234_5678);
    check("c2_pulses", n_pready, 32'd1);
    idle(1);

    run(1'b1, 16'h0020, 32'h55aa55aa, 0, 1, 1'b1, 32'hbadbadba, -1);
    check("c3_lat", obs_lat, 32'd4);
    check("c3_prdata", prdata, 32'h1234_5678);
    idle(1);

    run(1'b0, 16'h0002, 32'h0, 0, 0, 1'b0, 32'h0, -1);
    check("c4_lat", obs_lat, 32'd1);
    check("c4_nonseq", n_nonseq, 32'd0);
    idle(1);

    run(1'b0, 16'h0008, 32'h0, 5, 0, 1'b0, 32'h0badf00d, -1);
    check("c5_lat", obs_lat, 32'd8);
    check("c5_nonseq", n_nonseq, 32'd6);
    check("c5_prdata", prdata, 32'h0badf00d);

    run(1'b1, 16'hfffc, 32'h01234567, 2, 1, 1'b0, 32'h0, -1);
    check("c7_haddr", obs_haddr, 32'h2000_fffc);
    check("c7_lat", obs_lat, 32'd6);

    run(1'b1, 16'h0030, 32'h77778888, 0, 3, 1'b0, 32'h0, 3);
    idle(2);
    run(1'b1, 16'h0034, 32'h11112222, 0, 0, 1'b0, 32'h0, -1);
    check("c6_lat", obs_lat, 32'd3);
    check("c6_haddr", obs_haddr, 32'h2000_0034);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
